// File: rtl/if_axis_fifo.sv
// CPU memory-mapped bridge to AXI-stream.
// RX channel: AXIS slave -> FIFO -> CPU reads RXDATA.
// TX channel: CPU writes TXDATA -> FIFO -> AXIS master.
// Both channels carry TLAST. STATUS exposes fill levels and sticky error flags.

// Single-clock FIFO channel. Head entry is presented combinationally so the
// stream side sees stable data for as long as the entry is not popped.
module if_axis_fifo_chan #(
  parameter int EW = 9,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [EW-1:0] push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [EW-1:0] head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem[rd_ptr_q];

  // A flush discards any push/pop of the same cycle. A pop at full frees the
  // slot that a same-cycle push refills.
  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign push_ok = push_i && (!full_o || pop_ok) && !flush_i;

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count state; reset empties the FIFO immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data_i;
  end
endmodule

module if_axis_fifo #(
  parameter logic [7:0] SOC_SEGMENT     = 8'hE4,
  parameter logic [7:0] SOC_CLASS       = 8'hA9,
  parameter int         AXIS_DATA_WIDTH = 8,
  parameter int         FIFO_DEPTH_LOG2 = 3
) (
  input  logic                       axis_aclk_i,
  input  logic                       axis_aresetn_i,
  input  logic [31:0]                addr_i,
  input  logic [31:0]                data_i,
  output logic [31:0]                data_o,
  output logic                       data_access_o,
  input  logic                       data_w_i,
  output logic                       s_axis_tready_o,
  input  logic                       s_axis_tvalid_i,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic                       s_axis_tlast_i,
  output logic                       m_axis_tvalid_o,
  input  logic                       m_axis_tready_i,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                       m_axis_tlast_o
);
  localparam int W  = AXIS_DATA_WIDTH;
  localparam int AW = FIFO_DEPTH_LOG2;

  localparam logic [2:0] DEV_STATUS = 3'd1;
  localparam logic [2:0] DEV_RXDATA = 3'd2;
  localparam logic [2:0] DEV_TXDATA = 3'd3;
  localparam logic [2:0] DEV_CTRL   = 3'd4;

  // Bus decode
  logic [2:0]  device;
  logic        offset_hit;
  logic        acc;
  logic        acc_q, acc_d;
  logic        acc_edge;
  logic        rd_edge;
  logic        wr_edge;
  logic        rx_rd;
  logic        tx_wr;
  logic        ctrl_wr;
  logic        rx_flush;
  logic        tx_flush;
  logic        flag_clr;

  // Channel status
  logic [W:0]  rx_head, tx_head;
  logic [AW:0] rx_count, tx_count;
  logic        rx_full, rx_empty, tx_full, tx_empty;
  logic        rx_push;
  logic        tx_pop;

  // Registered outputs and sticky flags
  logic [31:0] data_o_q, data_o_d;
  logic        rx_stall_q, rx_stall_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic        tx_overflow_q, tx_overflow_d;
  logic        rx_underrun_q, rx_underrun_d;
  logic [31:0] status_word;
  logic [31:0] rxdata_word;
  logic        unused_ok;

  assign data_access_o = (addr_i[31:24] == SOC_SEGMENT) && (addr_i[23:16] == SOC_CLASS);
  assign device        = addr_i[6:4];
  assign offset_hit    = (device >= DEV_STATUS) && (device <= DEV_CTRL);
  assign acc           = data_access_o && offset_hit;

  // Only the first cycle of an access acts, so a CPU holding the bus for
  // several cycles still performs a single pop/push/flush.
  assign acc_edge = acc && !acc_q;
  assign rd_edge  = acc_edge && !data_w_i;
  assign wr_edge  = acc_edge && data_w_i;
  assign rx_rd    = rd_edge && (device == DEV_RXDATA);
  assign tx_wr    = wr_edge && (device == DEV_TXDATA);
  assign ctrl_wr  = wr_edge && (device == DEV_CTRL);
  assign rx_flush = ctrl_wr && data_i[0];
  assign tx_flush = ctrl_wr && data_i[1];
  assign flag_clr = ctrl_wr && data_i[2];

  // tready comes straight from the registered count, so it never depends on tvalid
  assign s_axis_tready_o = !rx_full;
  assign rx_push         = s_axis_tvalid_i && s_axis_tready_o;

  assign m_axis_tvalid_o = !tx_empty;
  assign m_axis_tdata_o  = tx_head[W-1:0];
  assign m_axis_tlast_o  = tx_head[W];
  assign tx_pop          = m_axis_tvalid_o && m_axis_tready_i;

  assign data_o = data_o_q;

  // Address bits outside the decode window and data bits above the stream width are don't-care
  assign unused_ok = ^{addr_i[15:7], addr_i[3:0], data_i[30:W]};

  if_axis_fifo_chan #(
    .EW (W + 1),
    .AW (AW)
  ) u_rx_fifo (
    .clk         (axis_aclk_i),
    .rst_n       (axis_aresetn_i),
    .push_i      (rx_push),
    .push_data_i ({s_axis_tlast_i, s_axis_tdata_i}),
    .pop_i       (rx_rd),
    .flush_i     (rx_flush),
    .head_o      (rx_head),
    .count_o     (rx_count),
    .full_o      (rx_full),
    .empty_o     (rx_empty)
  );

  if_axis_fifo_chan #(
    .EW (W + 1),
    .AW (AW)
  ) u_tx_fifo (
    .clk         (axis_aclk_i),
    .rst_n       (axis_aresetn_i),
    .push_i      (tx_wr),
    .push_data_i ({data_i[31], data_i[W-1:0]}),
    .pop_i       (m_axis_tready_i),
    .flush_i     (tx_flush),
    .head_o      (tx_head),
    .count_o     (tx_count),
    .full_o      (tx_full),
    .empty_o     (tx_empty)
  );

  // Assemble the STATUS word from current (pre-edge) state
  always_comb begin
    status_word        = '0;
    status_word[0]     = rx_empty;
    status_word[1]     = rx_full;
    status_word[2]     = tx_empty;
    status_word[3]     = tx_full;
    status_word[4]     = rx_overrun_q;
    status_word[5]     = tx_overflow_q;
    status_word[6]     = rx_underrun_q;
    status_word[15:8]  = 8'(rx_count);
    status_word[23:16] = 8'(tx_count);
  end

  // Assemble the RXDATA word: {valid, last, zeros, tdata}; all zero when empty
  always_comb begin
    rxdata_word = '0;
    if (!rx_empty) begin
      rxdata_word[W-1:0] = rx_head[W-1:0];
      rxdata_word[30]    = rx_head[W];
      rxdata_word[31]    = 1'b1;
    end
  end

  // Next-state for read data, access edge tracking and sticky flags
  always_comb begin
    acc_d    = acc;
    data_o_d = data_o_q;
    if (rd_edge) begin
      case (device)
        DEV_STATUS: data_o_d = status_word;
        DEV_RXDATA: data_o_d = rxdata_word;
        default:    data_o_d = '0;
      endcase
    end else if (data_access_o && !offset_hit && !data_w_i) begin
      data_o_d = '0;
    end

    // Producer stalled against a full RX FIFO; two cycles in a row is an overrun
    rx_stall_d    = s_axis_tvalid_i && rx_full;
    rx_overrun_d  = (rx_overrun_q && !flag_clr) || (rx_stall_d && rx_stall_q);
    tx_overflow_d = (tx_overflow_q && !flag_clr) || (tx_wr && tx_full && !tx_pop);
    rx_underrun_d = (rx_underrun_q && !flag_clr) || (rx_rd && rx_empty);
  end

  // Control/status registers
  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      acc_q         <= 1'b0;
      data_o_q      <= '0;
      rx_stall_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
      rx_underrun_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      data_o_q      <= data_o_d;
      rx_stall_q    <= rx_stall_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
      rx_underrun_q <= rx_underrun_d;
    end
  end
endmodule
